// File: rtl/hobbit_pkg.sv
// Shared constants and the parcel length rule for the Hobbit front-end parcel datapath.
package hobbit_pkg;

    localparam int PARCEL_W    = 16;
    localparam int MAX_PARCELS = 5;
    localparam int INST_W      = 80;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_3 = 3'd3;
    localparam logic [2:0] LEN_5 = 3'd5;

    // The two top bits of the first parcel encode the instruction length.
    function automatic logic [2:0] parcel_len(input logic [PARCEL_W-1:0] parcel);
        logic [2:0] len;
        if (!parcel[15]) begin
            len = LEN_1;
        end else if (!parcel[14]) begin
            len = LEN_3;
        end else begin
            len = LEN_5;
        end
        return len;
    endfunction

endpackage

// File: rtl/decode_parcel_queue_if.sv
// Fetch-side and decode-side handshake bundle of the parcel queue.
interface decode_parcel_queue_if #(
    parameter int PARCELS_IN = 2
);
    import hobbit_pkg::*;

    localparam int IN_CNT_W = $clog2(PARCELS_IN + 1);

    logic [PARCEL_W*PARCELS_IN-1:0] in_parcels;
    logic [IN_CNT_W-1:0]            in_count;
    logic                           in_valid;
    logic                           in_ready;
    logic [INST_W-1:0]              out_parcels;
    logic [2:0]                     out_len;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output in_parcels, in_count, in_valid, out_ready,
        input  in_ready, out_parcels, out_len, out_valid
    );

    modport slave (
        input  in_parcels, in_count, in_valid, out_ready,
        output in_ready, out_parcels, out_len, out_valid
    );

endinterface

// File: rtl/parcel_length.sv
// Combinational length decoder for the head parcel of an instruction.
module parcel_length
    import hobbit_pkg::*;
(
    input  logic [PARCEL_W-1:0] parcel,
    output logic [2:0]          len
);

    assign len = parcel_len(parcel);

endmodule

// File: rtl/decode_parcel_queue.sv
// Circular parcel buffer that assembles variable-length instructions for the decoder.
module decode_parcel_queue
    import hobbit_pkg::*;
#(
    parameter int PARCELS_IN = 2,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    decode_parcel_queue_if.slave           bus,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int IN_CNT_W = $clog2(PARCELS_IN + 1);

    logic [PARCEL_W-1:0] storage_q [BUF_DEPTH];
    logic [PARCEL_W-1:0] storage_d [BUF_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [2:0] head_len;
    logic       head_complete;
    logic       push;
    logic       pop;

    parcel_length u_head_len (
        .parcel (storage_q[rd_ptr_q]),
        .len    (head_len)
    );

    assign head_complete = (count_q != '0) && (count_q >= CNT_W'(head_len));
    assign bus.in_ready  = (BUF_DEPTH - int'(count_q)) >= PARCELS_IN;
    assign occupancy     = count_q;

    // A handshake during flush is ignored so the redirect wins cleanly.
    assign push = bus.in_valid && bus.in_ready && (bus.in_count != '0) && !flush;
    assign pop  = head_complete && bus.out_ready && !flush;

    always_comb begin
        bus.out_valid   = head_complete;
        bus.out_len     = head_complete ? head_len : 3'd0;
        bus.out_parcels = '0;
        for (int k = 0; k < MAX_PARCELS; k++) begin
            if (head_complete && (k < int'(head_len))) begin
                bus.out_parcels[k*PARCEL_W +: PARCEL_W] = storage_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        storage_d = storage_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                for (int i = 0; i < PARCELS_IN; i++) begin
                    if (i < int'(bus.in_count)) begin
                        storage_d[wr_ptr_q + PTR_W'(i)] = bus.in_parcels[i*PARCEL_W +: PARCEL_W];
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(bus.in_count);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(head_len);
            end
            count_d = count_q + (push ? CNT_W'(bus.in_count) : CNT_W'(0))
                              - (pop  ? CNT_W'(head_len)     : CNT_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Parcel storage carries no reset; count alone decides what is live.
    always_ff @(posedge clk) begin
        storage_q <= storage_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.in_valid && (bus.in_count > IN_CNT_W'(PARCELS_IN))));
            assert (count_q <= CNT_W'(BUF_DEPTH));
        end
    end

endmodule

// File: doc/decode_parcel_queue.md
Name: decode_parcel_queue

Overview:
Parcel-level instruction assembler between fetch and the one-parcel decoder. Accepts up to PARCELS_IN 16-bit parcels per cycle into a circular parcel buffer and determines instruction length (1, 3 or 5 parcels) from the head parcel. Presents one complete, left-aligned instruction per cycle under a valid/ready handshake. A flush input discards all buffered parcels on a control-flow redirect.

Parameters:
PARCELS_IN, 2, max parcels accepted per cycle (1..4).
BUF_DEPTH, 8, parcel buffer entries; power of two, >= PARCELS_IN + 4.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discard all buffered parcels.
in_parcels  input  16*PARCELS_IN  lane i = bits [16i+15:16i]; lane 0 is oldest.
in_count  input  $clog2(PARCELS_IN+1)  number of valid low lanes (0..PARCELS_IN).
in_valid  input  1  in_parcels/in_count meaningful.
in_ready  output  1  buffer can accept PARCELS_IN parcels this cycle.
out_parcels  output  80  instruction, parcel 0 in [15:0]; unused lanes zero.
out_len  output  3  1, 3 or 5 while out_valid; 0 otherwise.
out_valid  output  1  complete instruction at head.
out_ready  input  1  consumer accepts instruction.
occupancy  output  $clog2(BUF_DEPTH+1)  parcels currently buffered.

Behaviour:
- Length decode of head parcel p: p[15]==0 -> 1; p[15:14]==2'b10 -> 3; p[15:14]==2'b11 -> 5.
- State: storage array, rd_ptr and wr_ptr (log2 BUF_DEPTH bits, wrap modulo BUF_DEPTH), count.
- Reset: count=0, rd_ptr=wr_ptr=0; outputs in_ready=1, out_valid=0, out_len=0, out_parcels=0, occupancy=0. Storage contents not reset.
- in_ready = (BUF_DEPTH - count) >= PARCELS_IN; computed from registered count only, with no dependence on same-cycle pop.
- Push: in_valid & in_ready & in_count>0 writes lanes 0..in_count-1 to wr_ptr..wr_ptr+in_count-1 (wrapping); wr_ptr += in_count.
- in_count > PARCELS_IN is illegal; assert in simulation.
- in_valid with in_ready=0: nothing is written; the source must hold its data.
- out_valid = count>=1 & count>=len(head); combinational from registered state.
- out_parcels lane k = storage[rd_ptr+k] for k < len, else 0.
- Latency: a parcel pushed in cycle N can appear on the output no earlier than cycle N+1. No bypass from input to output.
- Pop: out_valid & out_ready advances rd_ptr by out_len.
- Same-cycle push and pop are allowed: count_next = count + pushed - popped.
- Partial instruction: with head length 5 and count 3, out_valid=0. It rises the cycle after the remaining parcels land.
- Wrap-around: instructions straddling the array end are assembled correctly.
- Flush: takes priority over push and pop. Next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0.
- out_valid may be 1 in the flush cycle, but a handshake in that cycle does not pop; the consumer must ignore it.
- rst overrides flush and all other inputs. rst mid-instruction drops partial parcels.
- Invariant: count <= BUF_DEPTH; assert.

Decomposition:
- Shared package hobbit_pkg:
  - PARCEL_W=16, MAX_PARCELS=5, INST_W=80.
  - Length constants LEN_1=3'd1, LEN_3=3'd3, LEN_5=3'd5.
  - Function parcel_len(parcel) -> 3-bit length.
- One natural sub-module: parcel_length, a combinational head-parcel length decoder, so the existing one-parcel decoder and future multi-decode can share it.
- Pointer/count logic and output mux stay in decode_parcel_queue.

Test Plan:
- Reset then push 16'h1234 (in_count=1) -> next cycle out_valid=1, out_len=1, out_parcels[15:0]=16'h1234, upper bits 0; pop -> occupancy=0.
- Push 16'h8001,16'h0002 then 16'h0003 over two cycles -> out_valid=0 until the third parcel lands; then out_len=3, out_parcels[47:0]=48'h0003_0002_8001.
- Push 16'hC000 + four operand parcels with out_ready=0 until full -> in_ready=0 at occupancy>BUF_DEPTH-2; popped out_len=5 carries all five parcels in order.
- Stream 1-parcel instructions at 2/cycle with out_ready=1 for 20 cycles, forcing wrap -> each instruction emerges in order exactly once; occupancy never exceeds BUF_DEPTH.
- Place a 5-parcel instruction starting at rd_ptr=6 (BUF_DEPTH=8) -> out_parcels correct across the wrap.
- Assert flush with 4 parcels buffered and a simultaneous push -> next cycle occupancy=0, out_valid=0, and the pushed parcels never appear.
